// File: rtl/alarm_scheduler_if.sv
// Time/alarm digits, buttons and indicator outputs shared by the time source and the scheduler.
// master drives time and buttons; slave (the scheduler) drives the LED/buzzer side.
interface alarm_scheduler_if;
  logic [3:0] secL, secH, minL, minH, hourL, hourH;
  logic [3:0] al_minL, al_minH, al_hourL, al_hourH;
  logic       alarm_en;
  logic       snooze_btn;
  logic       stop_btn;
  logic       led_n;
  logic       buzz;
  logic [1:0] state;
  logic       snoozed;

  modport master (
    output secL, secH, minL, minH, hourL, hourH,
    output al_minL, al_minH, al_hourL, al_hourH,
    output alarm_en, snooze_btn, stop_btn,
    input  led_n, buzz, state, snoozed
  );

  modport slave (
    input  secL, secH, minL, minH, hourL, hourH,
    input  al_minL, al_minH, al_hourL, al_hourH,
    input  alarm_en, snooze_btn, stop_btn,
    output led_n, buzz, state, snoozed
  );
endinterface

// File: rtl/alarm_scheduler.sv
// Arbitrates the shared LED/buzzer between the hourly chime and the daily alarm with snooze.
// Matches and button pulses act on the sampling edge; outputs are registered from the next state, no backpressure.
module alarm_scheduler #(
  parameter int CHIME_SECS  = 11,
  parameter int ALARM_SECS  = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic              div_clk,
  input  logic              rst,
  alarm_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHIME  = 2'd1,
    ALARM  = 2'd2,
    SNOOZE = 2'd3
  } state_e;

  localparam logic [8:0] CHIME_LD  = 9'(CHIME_SECS - 1);
  localparam logic [8:0] ALARM_LD  = 9'(ALARM_SECS - 1);
  localparam logic [8:0] SNOOZE_LD = 9'(SNOOZE_SECS - 1);
  localparam logic [1:0] MAX_SNZ   = 2'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [1:0] snz_q, snz_d;
  logic       led_n_q, led_n_d;
  logic       buzz_q, buzz_d;
  logic       snoozed_q, snoozed_d;
  logic       am, cm;

  assign am = bus.alarm_en
           && (bus.hourH == bus.al_hourH) && (bus.hourL == bus.al_hourL)
           && (bus.minH == bus.al_minH) && (bus.minL == bus.al_minL)
           && (bus.secH == 4'd0) && (bus.secL == 4'd0);

  assign cm = (bus.minH == 4'd5) && (bus.minL == 4'd9)
           && (bus.secH == 4'd5) && (bus.secL == 4'd9);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snz_d   = snz_q;
    case (state_q)
      IDLE: begin
        if (am) begin
          state_d = ALARM;
          cnt_d   = ALARM_LD;
          snz_d   = 2'd0;
        end else if (cm) begin
          state_d = CHIME;
          cnt_d   = CHIME_LD;
        end
      end
      CHIME: begin
        if (am) begin
          state_d = ALARM;
          cnt_d   = ALARM_LD;
          snz_d   = 2'd0;
        end else if (cnt_q == 9'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      ALARM: begin
        // stop beats snooze when both arrive in the same cycle
        if (!bus.alarm_en || bus.stop_btn) begin
          state_d = IDLE;
          snz_d   = 2'd0;
        end else if (bus.snooze_btn && (snz_q < MAX_SNZ)) begin
          state_d = SNOOZE;
          cnt_d   = SNOOZE_LD;
          snz_d   = snz_q + 2'd1;
        end else if (cnt_q == 9'd0) begin
          state_d = IDLE;
          snz_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      SNOOZE: begin
        if (!bus.alarm_en || bus.stop_btn) begin
          state_d = IDLE;
          snz_d   = 2'd0;
        end else if (cnt_q == 9'd0) begin
          state_d = ALARM;
          cnt_d   = ALARM_LD;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    led_n_d   = 1'b1;
    buzz_d    = 1'b0;
    snoozed_d = 1'b0;
    case (state_d)
      CHIME: led_n_d = 1'b0;
      ALARM: begin
        buzz_d  = 1'b1;
        // blink starts lit on every ring entry, including re-ring after snooze
        led_n_d = (state_q == ALARM) ? ~led_n_q : 1'b0;
      end
      SNOOZE: snoozed_d = 1'b1;
      default: led_n_d = 1'b1;
    endcase
  end

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 9'd0;
      snz_q     <= 2'd0;
      led_n_q   <= 1'b1;
      buzz_q    <= 1'b0;
      snoozed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snz_q     <= snz_d;
      led_n_q   <= led_n_d;
      buzz_q    <= buzz_d;
      snoozed_q <= snoozed_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.led_n   = led_n_q;
  assign bus.buzz    = buzz_q;
  assign bus.snoozed = snoozed_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Randomized bench for alarm_scheduler against a deadline-based reference model.
module tb_alarm_scheduler;
  localparam int CHIME_SECS  = 11;
  localparam int ALARM_SECS  = 60;
  localparam int SNOOZE_SECS = 300;
  localparam int MAX_SNOOZE  = 3;

  logic div_clk;
  logic rst;
  alarm_scheduler_if bus ();

  alarm_scheduler #(
    .CHIME_SECS (CHIME_SECS),
    .ALARM_SECS (ALARM_SECS),
    .SNOOZE_SECS(SNOOZE_SECS),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) dut (
    .div_clk(div_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus state: time of day in seconds, alarm time, enable
  int tod  = 0;
  int al_h = 0;
  int al_m = 0;
  bit en   = 1'b0;

  // reference model: activity kind plus absolute edge deadlines
  int now          = 0;
  int m_mode       = 0;
  int m_deadline   = 0;
  int m_ring_start = 0;
  int m_used       = 0;

  function automatic logic [4:0] exp_vec();
    case (m_mode)
      0: return 5'b00_1_0_0;
      1: return 5'b01_0_0_0;
      2: return {2'd2, 1'((now - m_ring_start) % 2), 1'b1, 1'b0};
      default: return 5'b11_1_0_1;
    endcase
  endfunction

  function automatic logic [4:0] dut_vec();
    return {bus.state, bus.led_n, bus.buzz, bus.snoozed};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_used = 0;
  endtask

  task automatic start_ring();
    m_mode       = 2;
    m_ring_start = now;
    m_deadline   = now + ALARM_SECS;
  endtask

  task automatic model_edge(input bit snz, input bit stp);
    bit am, cm;
    now++;
    am = en && (tod % 60 == 0) && (tod / 60 == al_h * 60 + al_m);
    cm = (tod % 3600) == 3599;
    case (m_mode)
      0: begin
        if (am) begin start_ring(); m_used = 0; end
        else if (cm) begin m_mode = 1; m_deadline = now + CHIME_SECS; end
      end
      1: begin
        if (am) begin start_ring(); m_used = 0; end
        else if (now == m_deadline) m_mode = 0;
      end
      2: begin
        if (!en || stp) begin m_mode = 0; m_used = 0; end
        else if (snz && m_used < MAX_SNOOZE) begin
          m_mode = 3; m_deadline = now + SNOOZE_SECS; m_used++;
        end else if (now == m_deadline) begin m_mode = 0; m_used = 0; end
      end
      default: begin
        if (!en || stp) begin m_mode = 0; m_used = 0; end
        else if (now == m_deadline) start_ring();
      end
    endcase
  endtask

  task automatic drive_inputs(input bit snz, input bit stp);
    int h, mi, s;
    h  = tod / 3600;
    mi = (tod / 60) % 60;
    s  = tod % 60;
    bus.hourH = 4'(h / 10);   bus.hourL = 4'(h % 10);
    bus.minH  = 4'(mi / 10);  bus.minL  = 4'(mi % 10);
    bus.secH  = 4'(s / 10);   bus.secL  = 4'(s % 10);
    bus.al_hourH = 4'(al_h / 10); bus.al_hourL = 4'(al_h % 10);
    bus.al_minH  = 4'(al_m / 10); bus.al_minL  = 4'(al_m % 10);
    bus.alarm_en   = en;
    bus.snooze_btn = snz;
    bus.stop_btn   = stp;
  endtask

  // one tick: inputs applied from just after the previous edge, sampled #1 after this one
  task automatic step(input bit snz, input bit stp);
    drive_inputs(snz, stp);
    @(posedge div_clk);
    model_edge(snz, stp);
    tod = (tod + 1) % 86400;
    #1;
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
  endtask

  function automatic int alarm_tod(input int offset);
    return (al_h * 3600 + al_m * 60 + offset + 86400) % 86400;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive_inputs(1'b0, 1'b0);
    repeat (2) @(posedge div_clk);
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== 5'b00_1_0_0) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", dut_vec(), 5'b00_1_0_0);
    end
    rst = 1'b0;
  endtask

  task automatic test_chime();
    int led_low = 0;
    en  = 1'b0;
    tod = 10 * 3600 + 59 * 60 + 58;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0);
      if (bus.led_n === 1'b0) led_low++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL chime step %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (led_low != CHIME_SECS) begin
      n_fail++;
      $display("FAIL chime_len: got %0d want %0d", led_low, CHIME_SECS);
    end
  endtask

  task automatic test_alarm_auto();
    int buzz_ticks = 0;
    al_h = 7; al_m = 30; en = 1'b1;
    tod  = alarm_tod(-2);
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b0);
      if (bus.buzz === 1'b1) buzz_ticks++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL alarm_auto step %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (buzz_ticks != ALARM_SECS || bus.state !== 2'd0) begin
      n_fail++;
      $display("FAIL alarm_len: got %0d ticks state %0d want %0d ticks state 0",
               buzz_ticks, bus.state, ALARM_SECS);
    end
  endtask

  task automatic test_snooze();
    int presses = 0, snz_ticks = 0, buzz_ticks = 0, exp_buzz = ALARM_SECS, cyc = 0;
    int press_age;
    bit p;
    al_h = $urandom_range(0, 23); al_m = $urandom_range(0, 59); en = 1'b1;
    tod  = alarm_tod(-1);
    press_age = $urandom_range(1, 58);
    do begin
      p = (m_mode == 2) && (presses < 4) && ((now + 1 - m_ring_start) == press_age);
      if (p) begin
        presses++;
        if (presses <= MAX_SNOOZE) exp_buzz += press_age;
        press_age = $urandom_range(1, 58);
      end
      step(p, 1'b0);
      cyc++;
      if (bus.snoozed === 1'b1) snz_ticks++;
      if (bus.buzz === 1'b1) buzz_ticks++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL snooze step %0d: got %b want %b", cyc, dut_vec(), exp_vec());
      end
    end while ((m_mode != 0 || cyc < 3) && cyc < 2000);
    n_checks++;
    if (cyc >= 2000 || snz_ticks != MAX_SNOOZE * SNOOZE_SECS) begin
      n_fail++;
      $display("FAIL snooze_len: got %0d snoozed ticks (cyc %0d) want %0d",
               snz_ticks, cyc, MAX_SNOOZE * SNOOZE_SECS);
    end
    n_checks++;
    if (buzz_ticks != exp_buzz) begin
      n_fail++;
      $display("FAIL snooze_ring: got %0d ring ticks want %0d", buzz_ticks, exp_buzz);
    end
  endtask

  task automatic test_preempt();
    bit chime_again = 1'b0;
    al_h = 12; al_m = 0; en = 1'b1;
    tod  = alarm_tod(-3);
    for (int i = 0; i < 75; i++) begin
      step(1'b0, 1'b0);
      if (i == 2) begin
        n_checks++;
        if (bus.state !== 2'd1 || bus.led_n !== 1'b0) begin
          n_fail++;
          $display("FAIL preempt_chime: got state %0d led_n %b want 1 0", bus.state, bus.led_n);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (bus.state !== 2'd2 || bus.buzz !== 1'b1) begin
          n_fail++;
          $display("FAIL preempt_alarm: got state %0d buzz %b want 2 1", bus.state, bus.buzz);
        end
      end
      if (i > 3 && bus.state === 2'd1) chime_again = 1'b1;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL preempt step %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (chime_again) begin
      n_fail++;
      $display("FAIL preempt_resume: got chime after alarm want none");
    end
  endtask

  task automatic test_button_priority();
    al_h = $urandom_range(0, 23); al_m = $urandom_range(0, 59); en = 1'b1;
    tod  = alarm_tod(0);
    step(1'b0, 1'b0);
    repeat ($urandom_range(1, 40)) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    n_checks++;
    if (bus.state !== 2'd0 || bus.snoozed !== 1'b0 || bus.buzz !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_vs_snooze: got state %0d snoozed %b want 0 0", bus.state, bus.snoozed);
    end
    tod = alarm_tod(0);
    step(1'b0, 1'b0);
    repeat ($urandom_range(1, 40)) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_checks++;
    if (dut_vec() !== exp_vec() || bus.snoozed !== 1'b1) begin
      n_fail++;
      $display("FAIL snooze_enter: got %b want %b", dut_vec(), exp_vec());
    end
    repeat ($urandom_range(1, 100)) step(1'b0, 1'b0);
    en = 1'b0;
    step(1'b0, 1'b0);
    n_checks++;
    if (bus.state !== 2'd0 || bus.snoozed !== 1'b0 || bus.led_n !== 1'b1) begin
      n_fail++;
      $display("FAIL en_drop: got state %0d snoozed %b led_n %b want 0 0 1",
               bus.state, bus.snoozed, bus.led_n);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_ring();
    bit retrig = 1'b0;
    al_h = $urandom_range(0, 23); al_m = $urandom_range(0, 59); en = 1'b1;
    tod  = alarm_tod(0);
    step(1'b0, 1'b0);
    repeat ($urandom_range(2, 30)) step(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== 5'b00_1_0_0) begin
      n_fail++;
      $display("FAIL reset_mid_ring: got %b want %b", dut_vec(), 5'b00_1_0_0);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0);
      if (bus.state !== 2'd0 && m_mode == 0) retrig = 1'b1;
    end
    n_checks++;
    if (retrig) begin
      n_fail++;
      $display("FAIL reset_retrigger: got activity after reset want idle");
    end
  endtask

  task automatic test_random();
    bit snz, stp;
    for (int w = 0; w < 4; w++) begin
      al_h = $urandom_range(0, 23); al_m = $urandom_range(0, 59); en = 1'b1;
      if (w % 2 == 0) tod = alarm_tod(-$urandom_range(1, 20));
      else tod = (al_h * 3600 + 3599 - $urandom_range(0, 10)) % 86400;
      for (int i = 0; i < 400; i++) begin
        snz = ($urandom_range(0, 29) == 0);
        stp = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 299) == 0) en = ~en;
        step(snz, stp);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random w%0d step %0d: got %b want %b", w, i, dut_vec(), exp_vec());
        end
      end
      en = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_chime();
    test_alarm_auto();
    test_snooze();
    test_preempt();
    test_button_priority();
    test_reset_mid_ring();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

- Sequences the clock's shared indicator LED and buzzer between two requesters: the hourly chime and a user-set daily alarm with snooze.
- Runs on the 1 s divided clock and samples the final BCD time digits once per tick.
- Resolves priority, times each activity, and drives a single registered LED/buzzer pair that replaces the stand-alone hourly LED driver.

## Interface

Parameters:
- CHIME_SECS, 11, chime length in ticks (xx:59:59 plus xx:00:00–xx:00:09)
- ALARM_SECS, 60, ring length in ticks before auto-dismiss
- SNOOZE_SECS, 300, snooze length in ticks
- MAX_SNOOZE, 3, snoozes allowed per alarm event

Ports:
- div_clk  in  1  1 s divided clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- secL, secH, minL, minH, hourL, hourH  in  4 each  current time, BCD, 24 h
- al_minL, al_minH, al_hourL, al_hourH  in  4 each  alarm time, BCD
- alarm_en  in  1  alarm armed (level)
- snooze_btn  in  1  debounced pulse, one div_clk cycle
- stop_btn  in  1  debounced pulse, one div_clk cycle
- led_n  out  1  shared indicator, active-low (1 = off)
- buzz  out  1  buzzer enable, active-high
- state  out  2  IDLE=0, CHIME=1, ALARM=2, SNOOZE=3
- snoozed  out  1  high while in SNOOZE

## Operation

- FSM with states IDLE, CHIME, ALARM, SNOOZE.
- Down-counter cnt is 9 bits; it must hold SNOOZE_SECS-1.
- Snooze counter snz is 2 bits.
- Alarm match (am): alarm_en=1, hour and minute digits equal the al_* digits, secH=0, secL=0.
- Chime match (cm): minH=5, minL=9, secH=5, secL=9.
- IDLE:
  - am -> ALARM, cnt=ALARM_SECS-1, snz=0.
  - Else cm -> CHIME, cnt=CHIME_SECS-1.
- CHIME:
  - am -> ALARM (alarm preempts chime), cnt=ALARM_SECS-1, snz=0.
  - Else cnt==0 -> IDLE.
  - Else cnt-1.
  - stop_btn and snooze_btn are ignored.
- ALARM, evaluated in priority order:
  1. alarm_en=0 or stop_btn -> IDLE, snz=0.
  2. snooze_btn with snz<MAX_SNOOZE -> SNOOZE, cnt=SNOOZE_SECS-1, snz+1. At snz==MAX_SNOOZE, snooze_btn is ignored.
  3. cnt==0 -> IDLE, snz=0.
  4. Else cnt-1.
- SNOOZE:
  - alarm_en=0 or stop_btn -> IDLE, snz=0.
  - cnt==0 -> ALARM, cnt=ALARM_SECS-1.
  - Else cnt-1.
  - cm and am are ignored.
- Outputs are registered and derived from the next state:
  - IDLE: led_n=1, buzz=0.
  - CHIME: led_n=0 steady, buzz=0.
  - ALARM: buzz=1; led_n=0 on entry, then toggles every tick.
  - SNOOZE: led_n=1, buzz=0, snoozed=1.
- Reset values: state=IDLE, led_n=1, buzz=0, snoozed=0, cnt=0, snz=0.
- Reset asserted mid-activity returns to IDLE immediately (asynchronous); no event is resumed after reset.

## Timing

- Match detection latency is one edge: the edge that samples xx:59:59 drives led_n low after the clock-to-Q delay.
- CHIME holds led_n low for exactly CHIME_SECS ticks.
- ALARM rings for ALARM_SECS ticks unless dismissed; the exit edge is the one that samples cnt==0.
- A button pulse takes effect on the edge that samples it; its outputs update in the same cycle as the state.
- Simultaneous stop_btn and snooze_btn in ALARM: stop wins.
- A pulse that spans more than one cycle is not permitted; behaviour in that case is per-cycle as specified above.
- Time inputs must be stable around div_clk rising edges; they come from the same clock domain.

## Test plan

- Hourly chime:
  - Stimulus: reset, then step time through 10:59:58 → 11:00:10, alarm_en=0.
  - Response: led_n low for exactly the 11 ticks after sampling 10:59:59; buzz stays 0; state returns to 0.
- Alarm with auto-dismiss:
  - Stimulus: alarm 07:30, alarm_en=1, time reaches 07:30:00.
  - Response: state=2 and buzz=1 next cycle; led_n alternates 0,1,0…; IDLE after 60 ticks.
- Snooze sequence:
  - Stimulus: in ALARM, send snooze_btn 4 times, one per ring.
  - Response: three SNOOZE periods of 300 ticks each with snoozed=1; the fourth press is ignored and the alarm rings until the 60-tick timeout.
- Preemption:
  - Stimulus: alarm 12:00, time passes 11:59:59 → 12:00:00.
  - Response: CHIME at 11:59:59; ALARM with buzz=1 from 12:00:00; the chime does not resume.
- Button priority:
  - Stimulus: stop_btn and snooze_btn high in the same ALARM cycle.
  - Response: state=0, snoozed=0.
  - Stimulus: alarm_en dropped during SNOOZE.
  - Response: IDLE on that edge.
- Reset mid-ring:
  - Stimulus: rst pulsed asynchronously during ALARM.
  - Response: led_n=1, buzz=0, state=0 immediately, no retrigger until the next match.
